// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg: shared types and constants for the ring-oscillator frequency meter.
//   state_t  : measurement FSM states
//   MIN_SYNC : smallest synchronizer depth that is safe for an async input
package ro_meter_pkg;
    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;
    localparam int MIN_SYNC = 2;
endpackage

// File: rtl/ro_freq_meter_sync_ff.sv
// sync_ff: N_SYNC-deep flop chain bringing an asynchronous bit into the clk domain.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output
module sync_ff
    import ro_meter_pkg::*;
#(
    parameter int N_SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    // Depths below the metastability minimum are quietly raised to it.
    localparam int DEPTH = (N_SYNC < MIN_SYNC) ? MIN_SYNC : N_SYNC;

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[DEPTH-2:0], d};
    end

    assign q = chain[DEPTH-1];
endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: counts rising edges of an async oscillator over a window of clk cycles.
//   clk     : system clock
//   rst     : synchronous active-high reset, discards any running measurement
//   start   : measurement request, honoured only while idle
//   win_len : window length in clk cycles, captured on acceptance
//   ro_in   : asynchronous oscillator / delay-chain output
//   busy    : high from acceptance until the result cycle has passed
//   done    : one-cycle pulse in the cycle count/ovfl are published
//   count   : edges seen in the last window, held until the next done
//   ovfl    : last measurement saturated the edge counter
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int N_WIN  = 16,
    parameter int N_CNT  = 16,
    parameter int N_SYNC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_WIN-1:0] win_len,
    input  logic             ro_in,
    output logic             busy,
    output logic             done,
    output logic [N_CNT-1:0] count,
    output logic             ovfl
);
    state_t           state;
    logic [N_WIN-1:0] win_cnt;
    logic [N_CNT-1:0] edge_cnt;
    logic [N_CNT-1:0] edge_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             ro_s;
    logic             ro_d;
    logic             edge_p;
    logic             hit;
    logic             at_max;
    logic             last;

    sync_ff #(.N_SYNC(N_SYNC)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ro_in),
        .q   (ro_s)
    );

    // Edge detector runs in every state so ro_d is never stale at ARM.
    always_ff @(posedge clk) begin
        if (rst) ro_d <= 1'b0;
        else     ro_d <= ro_s;
    end

    assign edge_p = ro_s & ~ro_d;

    // Next edge count and saturation flag, so the cycle that closes the
    // window can publish a result that already includes its own edge.
    assign hit      = (state == COUNT) && edge_p;
    assign at_max   = &edge_cnt;
    assign edge_nxt = (hit && !at_max) ? edge_cnt + N_CNT'(1) : edge_cnt;
    assign sat_nxt  = sat | (hit & at_max);

    // Final cycle before DONE: ARM with an empty window, or the last COUNT cycle.
    assign last = (state == ARM)   ? (win_cnt == '0) :
                  (state == COUNT) ? (win_cnt == N_WIN'(1)) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            ovfl     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_cnt  <= win_len;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    state <= last ? DONE : COUNT;
                end
                COUNT: begin
                    edge_cnt <= edge_nxt;
                    sat      <= sat_nxt;
                    win_cnt  <= win_cnt - N_WIN'(1);
                    if (last) state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Results are registered on entry to DONE so they appear with done.
            if (last) begin
                done  <= 1'b1;
                count <= edge_nxt;
                ovfl  <= sat_nxt;
            end
        end
    end
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: scoreboard bench for ro_freq_meter (4-bit counter to reach saturation).
module tb_ro_freq_meter;
    localparam int N_WIN = 16;
    localparam int N_CNT = 4;

    typedef struct {
        int done_cyc;
        int lo;
        int hi;
        bit ov;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N_WIN-1:0] win_len;
    logic             ro_in;
    logic             busy;
    logic             done;
    logic [N_CNT-1:0] count;
    logic             ovfl;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   half = 0;
    int   busy_from = 0;
    int   busy_until = -1;
    exp_t sb[$];

    ro_freq_meter #(.N_WIN(N_WIN), .N_CNT(N_CNT), .N_SYNC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .win_len (win_len),
        .ro_in   (ro_in),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .ovfl    (ovfl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Oscillator: toggles every 'half' clk cycles, offset from the clk edge; half=0 holds it.
    initial begin
        int ph;
        ph = 0;
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (half != 0) begin
                ph++;
                if (ph >= half) begin
                    ro_in = ~ro_in;
                    ph = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge: start is sampled on the next posedge, which becomes cycle k.
    task automatic launch(input int w, input int lo, input int hi, input bit ov);
        int k;
        k = cyc + 1;
        win_len = N_WIN'(w);
        start = 1'b1;
        sb.push_back('{k + w + 1, lo, hi, ov});
        busy_from = k;
        busy_until = k + w + 1;
    endtask

    // Monitor: every cycle compares done and busy against the model, and
    // pops a result when its done cycle arrives.
    initial forever begin
        exp_t e;
        logic exp_done;
        @(posedge clk);
        #1;
        exp_done = (sb.size() != 0) && (cyc == sb[0].done_cyc);
        check("done", done, exp_done);
        check("busy", busy, (cyc >= busy_from) && (cyc <= busy_until));
        if (exp_done) begin
            e = sb.pop_front();
            if (e.lo == e.hi) check("count", count, e.lo);
            else check("count_in_range", (count >= e.lo) && (count <= e.hi), 1);
            check("ovfl", ovfl, e.ov);
        end
    end

    initial begin
        int k0;
        rst = 1'b1;
        start = 1'b1;
        win_len = 16'd5;
        half = 2;
        @(negedge clk);
        repeat (3) begin
            check("rst_count", count, 0);
            check("rst_ovfl", ovfl, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);

        // nominal: period 8, W=64
        half = 4;
        repeat (4) @(negedge clk);
        launch(64, 7, 9, 0);
        @(negedge clk) start = 1'b0;
        repeat (70) @(negedge clk);

        // empty window
        launch(0, 0, 0, 0);
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);

        // saturation: period 4, W=100 -> about 25 edges into a 4-bit counter
        half = 2;
        repeat (4) @(negedge clk);
        launch(100, 15, 15, 1);
        @(negedge clk) start = 1'b0;
        repeat (105) @(negedge clk);

        // static input clears a previous overflow
        half = 0;
        repeat (8) @(negedge clk);
        launch(10, 0, 0, 0);
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);

        // start and win_len changes while busy are ignored
        half = 4;
        repeat (4) @(negedge clk);
        k0 = cyc + 1;
        launch(20, 1, 4, 0);
        @(negedge clk) start = 1'b0;
        while (cyc < k0 + 4) @(negedge clk);
        start = 1'b1;
        win_len = 16'd50;
        @(negedge clk) start = 1'b0;
        while (cyc < k0 + 21) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        launch(16, 1, 3, 0);
        @(negedge clk) start = 1'b0;
        repeat (22) @(negedge clk);

        // reset in the middle of COUNT discards the run
        k0 = cyc + 1;
        launch(64, 7, 9, 0);
        @(negedge clk) start = 1'b0;
        while (cyc < k0 + 9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        busy_until = -1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ovfl", ovfl, 0);
        repeat (70) @(negedge clk);

        // recovery run after reset
        launch(32, 3, 5, 0);
        @(negedge clk) start = 1'b0;
        repeat (38) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
